gf_divider_arbiter: RTL and testbench
=====================================

# gf_divider_arbiter

Round-robin arbiter and sequencer that shares one `finite_divider` instance among N_REQ requesters. The block accepts numerator/denominator pairs over valid/ready, drives the divider's start/numerator/denominator timing, and returns the dual-basis quotient tagged with the requester index. It sits between the per-lane Chien/Forney-style consumers and the single GF(2^M) divider in the BCH decoder datapath.

## Interface
- `M`, 4: field degree; field polynomial is `BCH_POLYNOMIAL(M)` and must be a trinomial, the same restriction as the divider.
- `N_REQ`, 4: number of requesters, 2..16.
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input N_REQ: per-requester request valid.
- `req_ready` output N_REQ: one-hot grant/accept, combinational.
- `req_numer` input M*N_REQ: standard-basis numerators, slice i is `[i*M+:M]`.
- `req_denom` input M*N_REQ: standard-basis denominators, same slicing.
- `resp_valid` output 1: registered response valid.
- `resp_ready` input 1: response consumer ready.
- `resp_id` output clog2(N_REQ): index of the originating requester.
- `resp_data` output M: dual-basis quotient numer/denom.
- `resp_err` output 1: zero-denominator flag (see Configuration).

## Operation
- FSM states: IDLE, START, WAIT, RESP. Reset state is IDLE.
- IDLE: if any `req_valid` is set, grant the first set bit searching upward (with wrap) from `last+1`. The grant is signalled by asserting `req_ready[g]` in that cycle.
  - On that edge: capture numer, denom and id into holding registers, set `last<=g`, and go to START.
  - `req_ready` is all-zero in every other state.
- START: drive divider `start=1` with `standard_denom` from the holding register, then go to WAIT.
- WAIT: hold the divider's `standard_numer` at the held numerator throughout.
  - On the first edge where divider `busy==0`: latch divider `dual_out` into `resp_data`, set `resp_valid=1`, and go to RESP.
- RESP: hold `resp_valid`, `resp_id`, `resp_data` and `resp_err` stable until `resp_valid && resp_ready`. On that edge, clear `resp_valid` and go to IDLE.
- The round-robin pointer `last` resets to N_REQ-1, so requester 0 has top priority after reset.
- Only one division is in flight at a time. No request is accepted while in START, WAIT or RESP.
- `req_numer`/`req_denom` are sampled only on the accept edge. Requesters may change them afterwards.
- Reset mid-operation:
  - All registers clear asynchronously; any in-flight result is discarded and no response is issued.
  - The divider may still be busy. The next START restarts it, because `start` overrides `busy`.
- The divider's own registers have no reset. The arbiter never samples `dual_out` except in WAIT after its own START.

## Timing
- Reset values: `resp_valid=0`, `resp_id=0`, `resp_data=0`, `resp_err=0`, `req_ready=0`, `last=N_REQ-1`, state IDLE.
- Accept at edge E0. START occupies cycle E0–E1. The divider is busy for M-1 cycles (E1–E_M).
- `resp_valid` rises after edge E_{M+1}, i.e. M+1 edges after acceptance.
- Minimum spacing between accepts is M+3 edges, when `resp_ready` is held high.
- A request arriving while `resp_valid=1` waits in IDLE arbitration. The earliest it can be accepted is the cycle after the response handshake.
- When `req_valid` is asserted and dropped in the same cycle with no grant, nothing is recorded; there is no request latching.

## Configuration
- `BCH_DIV_ZERO_CHECK_EN` defined:
  - An accepted request with denom==0 skips START/WAIT and goes directly to RESP on the next edge.
  - The response has `resp_err=1` and `resp_data=0`; the divider is not started.
  - `resp_valid` rises 1 edge after acceptance.
- Not defined: zero denominators are sequenced normally, `resp_err` is tied 0, and `resp_data` is whatever the divider produces (undefined).

## Test plan
- Single request, M=4: requester 2 sends numer=1, denom=1 → `req_ready=4'b0100` for one cycle, `resp_valid` M+1=5 edges later, `resp_id=2`, `resp_data==standard_to_dual(4,1)`.
- Exhaustive field check: for requester 0, every numer in 0..15 and denom in 1..15 → `resp_data` equals the dual-basis conversion of numer·denom⁻¹ from the model.
- Fairness: all four `req_valid` held high with `resp_ready=1` → grant order 0,1,2,3,0,…, exactly M+3 edges apart.
- Back-pressure: `resp_ready=0` for 10 cycles after `resp_valid` → response fields stable, `req_ready` stays 0, next grant comes one cycle after the handshake.
- Reset mid-WAIT: assert `reset_n=0` 2 cycles after accept → all outputs 0 immediately. A new request after release completes with the correct quotient.
- Zero denominator with `BCH_DIV_ZERO_CHECK_EN`: denom=0, numer=5 → `resp_valid` 1 edge after accept, `resp_err=1`, `resp_data=0`. Without the macro, `resp_err` stays 0.

Source files
------------

// File: rtl/gf_divider_arbiter.sv
// -----------------------------------------------------------------------------
// gf_divider_arbiter.sv
//
// Purpose:
//   Shares a single GF(2^M) finite_divider among N_REQ requesters. Requests are
//   granted round-robin, the divider is sequenced through start/busy, and the
//   dual-basis quotient is returned tagged with the requester index. Only one
//   division is in flight at a time.
//
// Optional feature macro:
//   BCH_DIV_ZERO_CHECK_EN - when defined, a zero denominator bypasses the
//   divider and returns resp_err=1 with resp_data=0 one edge after acceptance.
//   When undefined, zero denominators are divided normally and resp_err is 0.
//
// Modules in this file:
//   finite_divider     - sequential GF(2^M) divider, M-1 busy cycles
//   gf_divider_arbiter - top: round-robin arbiter + divider sequencer
//
// Top ports (gf_divider_arbiter):
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   [N_REQ]    per-requester request valid
//   req_ready  out  [N_REQ]    one-hot grant (combinational, IDLE only)
//   req_numer  in   [M*N_REQ]  standard-basis numerators, slice i = [i*M+:M]
//   req_denom  in   [M*N_REQ]  standard-basis denominators, same slicing
//   resp_valid out             registered response valid
//   resp_ready in              response consumer ready
//   resp_id    out  [clog2(N)] originating requester index
//   resp_data  out  [M]        dual-basis quotient numer/denom
//   resp_err   out             zero-denominator flag
// -----------------------------------------------------------------------------

// finite_divider
//   start          in   load a new denominator (overrides busy)
//   standard_numer in   numerator, must be held stable until the result is used
//   standard_denom in   denominator, sampled on the start edge
//   busy           out  high for M-1 cycles after the start edge
//   dual_out       out  dual-basis numer * denom^-1, valid once busy drops
module finite_divider #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         start,
  input  logic [M-1:0] standard_numer,
  input  logic [M-1:0] standard_denom,
  output logic         busy,
  output logic [M-1:0] dual_out
);

  localparam int CNT_W = $clog2(M) + 1;

  // Primitive trinomial x^M + x^k + 1 for the supported field degrees.
  function automatic logic [M:0] bch_polynomial(input int m);
    logic [M:0] p;
    int         k;
    case (m)
      5:       k = 2;
      9:       k = 4;
      10:      k = 3;
      11:      k = 2;
      default: k = 1;
    endcase
    p = '0;
    p[M] = 1'b1;
    p[0] = 1'b1;
    p = p | ((M+1)'(1) << k);
    return p;
  endfunction

  localparam logic [M:0]   POLY    = bch_polynomial(M);
  localparam logic [M-1:0] POLY_LO = POLY[M-1:0];

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    return (x << 1) ^ ({M{x[M-1]}} & POLY_LO);
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ t;
      t = mul_alpha(t);
    end
    return p;
  endfunction

  // Bit j is Tr(alpha^j); trace computed as the sum of the Frobenius conjugates.
  function automatic logic [M-1:0] calc_tr_mask();
    logic [M-1:0] mask;
    logic [M-1:0] x;
    logic [M-1:0] y;
    logic [M-1:0] s;
    mask = '0;
    x = {{(M-1){1'b0}}, 1'b1};
    for (int j = 0; j < M; j++) begin
      s = '0;
      y = x;
      for (int k = 0; k < M; k++) begin
        s = s ^ y;
        y = gf_mul(y, y);
      end
      mask[j] = s[0];
      x = mul_alpha(x);
    end
    return mask;
  endfunction

  localparam logic [M-1:0] TR_MASK = calc_tr_mask();

  // Dual-basis coordinate i is Tr(a * alpha^i), i.e. parity of (a*alpha^i) & TR_MASK.
  function automatic logic [M-1:0] to_dual(input logic [M-1:0] a);
    logic [M-1:0] d;
    logic [M-1:0] t;
    d = '0;
    t = a;
    for (int i = 0; i < M; i++) begin
      d[i] = ^(t & TR_MASK);
      t = mul_alpha(t);
    end
    return d;
  endfunction

  logic [M-1:0]     sq_q, sq_d;
  logic [M-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign busy = (cnt_q != '0);

  // Inverse by exponentiation: d^-1 = d^(2^M-2) = prod_{j=1..M-1} d^(2^j).
  // Each busy cycle folds in one squared power, so M-1 cycles are needed.
  always_comb begin
    sq_d  = sq_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      sq_d  = gf_mul(standard_denom, standard_denom);
      acc_d = {{(M-1){1'b0}}, 1'b1};
      cnt_d = CNT_W'(M - 1);
    end else if (busy) begin
      acc_d = gf_mul(acc_q, sq_q);
      sq_d  = gf_mul(sq_q, sq_q);
      cnt_d = cnt_q - 1'b1;
    end
  end

  // No reset: a new start always reloads every register.
  always_ff @(posedge clk) begin
    sq_q  <= sq_d;
    acc_q <= acc_d;
    cnt_q <= cnt_d;
  end

  assign dual_out = to_dual(gf_mul(standard_numer, acc_q));

endmodule

module gf_divider_arbiter #(
  parameter int M     = 4,
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [M*N_REQ-1:0]         req_numer,
  input  logic [M*N_REQ-1:0]         req_denom,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [M-1:0]               resp_data,
  output logic                       resp_err
);

  localparam int ID_W = $clog2(N_REQ);

`ifdef BCH_DIV_ZERO_CHECK_EN
  localparam bit ZERO_CHK = 1'b1;
`else
  localparam bit ZERO_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [M-1:0]    numer_q, numer_d;
  logic [M-1:0]    denom_q, denom_d;
  logic            resp_valid_q, resp_valid_d;
  logic [M-1:0]    resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic [M-1:0]     numer_sel;
  logic [M-1:0]     denom_sel;
  logic [N_REQ-1:0] ready_c;

  logic            div_start;
  logic            div_busy;
  logic [M-1:0]    div_dual;

  finite_divider #(.M(M)) u_div (
    .clk            (clk),
    .start          (div_start),
    .standard_numer (numer_q),
    .standard_denom (denom_q),
    .busy           (div_busy),
    .dual_out       (div_dual)
  );

  // Round-robin search starting just above the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    numer_sel = '0;
    denom_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        numer_sel = req_numer[i*M +: M];
        denom_sel = req_denom[i*M +: M];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    numer_d      = numer_q;
    denom_d      = denom_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    ready_c      = '0;
    div_start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          for (int i = 0; i < N_REQ; i++) begin
            ready_c[i] = (grant_idx == ID_W'(i));
          end
          numer_d = numer_sel;
          denom_d = denom_sel;
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = START;
        end
      end
      START: begin
        if (ZERO_CHK && (denom_q == '0)) begin
          // Zero denominator: skip the divider entirely.
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else begin
          div_start = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (!div_busy) begin
          resp_valid_d = 1'b1;
          resp_data_d  = div_dual;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      numer_q      <= '0;
      denom_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      numer_q      <= numer_d;
      denom_q      <= denom_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Grant is suppressed while reset is held so no accept is signalled.
  assign req_ready  = ready_c & {N_REQ{reset_n}};
  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_gf_divider_arbiter.sv
`timescale 1ns/1ps
module tb_gf_divider_arbiter;

  localparam int M = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [M*N-1:0] req_numer;
  logic [M*N-1:0] req_denom;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [M-1:0]   resp_data;
  logic           resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  int         gid [5];
  int         gcyc[5];
  int         ng, cyc, lat;
  logic [3:0] rdy;
  logic [3:0] q;
  logic [1:0] rid;
  logic       err;
  logic       ok;

  always #5 clk = ~clk;

  gf_divider_arbiter #(.M(M), .N_REQ(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_numer  (req_numer),
    .req_denom  (req_denom),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model for GF(16), x^4+x+1.
  function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] m_inv(input logic [3:0] b);
    logic [3:0] r;
    r = '0;
    for (int x = 1; x < 16; x++) if (m_mul(b, 4'(x)) == 4'h1) r = 4'(x);
    return r;
  endfunction

  // Hand-derived trace-dual coordinates for x^4+x+1.
  function automatic logic [3:0] m_dual(input logic [3:0] a);
    return {a[0] ^ a[3], a[1], a[2], a[3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_resp(output int l);
    l = 0;
    while (!resp_valid && l < 40) begin
      step();
      l++;
    end
  endtask

  // Single request from an idle arbiter, full handshake.
  task automatic do_div(input int id, input logic [3:0] n, input logic [3:0] d,
                        output logic [3:0] rdy_o, output int lat_o,
                        output logic [3:0] q_o, output logic [1:0] rid_o,
                        output logic err_o);
    req_numer[id*4 +: 4] = n;
    req_denom[id*4 +: 4] = d;
    req_valid = '0;
    req_valid[id] = 1'b1;
    #1;
    rdy_o = req_ready;
    step();
    req_valid = '0;
    wait_resp(lat_o);
    q_o   = resp_data;
    rid_o = resp_id;
    err_o = resp_err;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_numer  = '0;
    req_denom  = '0;
    resp_ready = 1'b0;
    step();
    step();
    req_valid = 4'hF;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id",    resp_id,    0);
    check("rst_resp_data",  resp_data,  0);
    check("rst_resp_err",   resp_err,   0);
    check("rst_req_ready",  req_ready,  0);
    req_valid = '0;
    reset_n = 1'b1;
    step();

    // Single request from requester 2, 1/1.
    do_div(2, 4'h1, 4'h1, rdy, lat, q, rid, err);
    check("t1_ready",   rdy, 4'b0100);
    check("t1_latency", lat, 5);
    check("t1_id",      rid, 2);
    check("t1_data",    q,   4'h8);
    check("t1_err",     err, 0);
    #1;
    check("t1_valid_clr", resp_valid, 0);

    // Every numerator/denominator pair through requester 0.
    ok = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int d = 1; d < 16; d++) begin
        do_div(0, 4'(n), 4'(d), rdy, lat, q, rid, err);
        check($sformatf("exh_q n=%0d d=%0d", n, d), q, m_dual(m_mul(4'(n), m_inv(4'(d)))));
        if (lat != 5 || rdy != 4'b0001 || rid != 2'd0) ok = 1'b0;
      end
    end
    check("exh_timing_id", ok, 1);

    // Reset two cycles after accept.
    req_numer[15:12] = 4'h3;
    req_denom[15:12] = 4'h5;
    req_valid = 4'b1000;
    #1;
    step();
    req_valid = '0;
    step();
    step();
    reset_n = 1'b0;
    req_valid = 4'hF;
    #1;
    check("rmid_valid", resp_valid, 0);
    check("rmid_ready", req_ready,  0);
    check("rmid_id",    resp_id,    0);
    check("rmid_data",  resp_data,  0);
    check("rmid_err",   resp_err,   0);
    step();
    req_valid = '0;
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_valid !== 1'b0) ok = 1'b0;
    end
    check("rmid_no_resp", ok, 1);
    do_div(1, 4'h9, 4'hE, rdy, lat, q, rid, err);
    check("rmid_new_ready", rdy, 4'b0010);
    check("rmid_new_lat",   lat, 5);
    check("rmid_new_data",  q,   4'h9);
    check("rmid_new_id",    rid, 1);

    // Back-pressure with a second request pending.
    req_numer[7:4] = 4'h6;
    req_denom[7:4] = 4'h3;
    req_valid = 4'b0010;
    #1;
    check("bp_ready", req_ready, 4'b0010);
    step();
    req_numer[15:12] = 4'h2;
    req_denom[15:12] = 4'h7;
    req_valid = 4'b1000;
    wait_resp(lat);
    check("bp_lat",  lat,       5);
    check("bp_data", resp_data, 4'h4);
    check("bp_id",   resp_id,   1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_valid !== 1'b1 || resp_data !== 4'h4 || resp_id !== 2'd1 ||
          resp_err !== 1'b0 || req_ready !== 4'b0000) ok = 1'b0;
    end
    check("bp_stable", ok, 1);
    resp_ready = 1'b1;
    #1;
    check("bp_ready_hold", req_ready, 0);
    step();
    resp_ready = 1'b0;
    #1;
    check("bp_regrant",   req_ready,  4'b1000);
    check("bp_valid_clr", resp_valid, 0);
    step();
    req_valid = '0;
    wait_resp(lat);
    check("bp2_lat",  lat,       5);
    check("bp2_data", resp_data, 4'hB);
    check("bp2_id",   resp_id,   3);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Fairness from a fresh reset, all requesters pending.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_numer[i*4 +: 4] = 4'h1;
      req_denom[i*4 +: 4] = 4'h1;
    end
    for (int i = 0; i < 5; i++) begin
      gid[i]  = -1;
      gcyc[i] = -100;
    end
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    #1;
    cyc = 0;
    ng  = 0;
    ok  = 1'b1;
    while (ng < 5 && cyc < 80) begin
      if (req_ready != '0) begin
        if ($countones(req_ready) != 1) ok = 1'b0;
        for (int b = 0; b < N; b++) if (req_ready[b]) gid[ng] = b;
        gcyc[ng] = cyc;
        ng++;
      end
      step();
      cyc++;
    end
    check("fair_count",  ng, 5);
    check("fair_onehot", ok, 1);
    for (int i = 0; i < 5; i++) check($sformatf("fair_order%0d", i), gid[i], i % 4);
    for (int i = 1; i < 5; i++) check($sformatf("fair_gap%0d", i), gcyc[i] - gcyc[i-1], 7);
    req_valid = '0;
    repeat (12) step();
    resp_ready = 1'b0;

    // Zero denominator.
    do_div(2, 4'h5, 4'h0, rdy, lat, q, rid, err);
    check("zero_ready", rdy, 4'b0100);
    check("zero_id",    rid, 2);
`ifdef BCH_DIV_ZERO_CHECK_EN
    check("zero_lat",  lat, 1);
    check("zero_err",  err, 1);
    check("zero_data", q,   0);
`else
    check("zero_lat",  lat, 5);
    check("zero_err",  err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
